// File: rtl/std_smult_arbiter.sv
// -----------------------------------------------------------------------------
// std_smult_arbiter
//
// Round-robin scheduler sharing one pipelined signed multiplier among NREQ
// requesters that use a go/done handshake. Every issued operation carries its
// requester index as a tag. The result returns on the shared bus together
// with a one-cycle done pulse for that requester.
//
// Parameters:
//   width   - operand/result width (signed two's complement)
//   NREQ    - number of requesters (2..16)
//   LATENCY - cycles from the grant cycle to the done cycle (>=1)
//
// Ports:
//   clk    in   1           rising-edge clock
//   reset  in   1           asynchronous active-low reset
//   go     in   NREQ        per-requester request, held until its done
//   left   in   NREQ*width  packed left operands, requester i at [i*width +: width]
//   right  in   NREQ*width  packed right operands, same packing
//   out    out  width       shared result, nonzero only alongside a done bit
//   done   out  NREQ        one-hot completion pulse (registered)
//   grant  out  NREQ        one-hot issue indication for this cycle (combinational)
//
// Optional feature macro: STD_SMULT_ARBITER_SATURATE_EN
//   defined   -> result saturates to the signed width range in the final stage
//   undefined -> result is the low width bits of the product (wrap-around)
// -----------------------------------------------------------------------------
module std_smult_arbiter #(
    parameter int width   = 32,
    parameter int NREQ    = 4,
    parameter int LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         go,
    input  logic [NREQ*width-1:0]   left,
    input  logic [NREQ*width-1:0]   right,
    output logic [width-1:0]        out,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Carried product width. Wrap-around only ever needs the low width bits of
    // the full product, which are identical to a width-bit multiply, so the
    // pipeline carries only those; saturation needs the whole 2*width product.
`ifdef STD_SMULT_ARBITER_SATURATE_EN
    localparam int CW = 2 * width;
`else
    localparam int CW = width;
`endif

    function automatic logic [NREQ-1:0] onehot_f(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Reduce the carried product to the result width.
    function automatic logic [width-1:0] finalize_f(input logic [CW-1:0] p);
`ifdef STD_SMULT_ARBITER_SATURATE_EN
        logic [width:0] top;
        top = p[CW-1:width-1];
        // In range exactly when the sign bit of the result is replicated above it.
        if ((top == {(width+1){1'b0}}) || (top == {(width+1){1'b1}})) begin
            return p[width-1:0];
        end else if (p[CW-1]) begin
            return {1'b1, {(width-1){1'b0}}};
        end else begin
            return {1'b0, {(width-1){1'b1}}};
        end
`else
        return p;
`endif
    endfunction

    logic [PW-1:0]          ptr_r;
    logic [NREQ-1:0]        inflight_r;
    logic [NREQ-1:0]        inflight_next_s;
    logic [NREQ-1:0]        done_r;
    logic [width-1:0]       out_r;
    logic [NREQ-1:0]        elig_s;
    logic [NREQ-1:0]        grant_s;
    logic [PW-1:0]          win_s;
    logic                   found_s;
    logic signed [width-1:0] a_s;
    logic signed [width-1:0] b_s;
    logic signed [CW-1:0]   a_x_s;
    logic signed [CW-1:0]   b_x_s;
    logic [CW-1:0]          prod_s;
    logic                   fin_vld_s;
    logic [PW-1:0]          fin_tag_s;
    logic [CW-1:0]          fin_prod_s;

    // A requester completing this cycle is not eligible, so a grant and a done
    // can never coincide for the same requester.
    assign elig_s = go & ~inflight_r & ~done_r;

    // Round-robin search starting at ptr_r, wrapping modulo NREQ.
    always_comb begin : arb_c
        logic [PW:0] sum_v;
        sum_v   = {(PW+1){1'b0}};
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sum_v = {1'b0, ptr_r} + (PW+1)'(k);
            if (sum_v >= (PW+1)'(NREQ)) begin
                sum_v = sum_v - (PW+1)'(NREQ);
            end else begin
                sum_v = sum_v;
            end
            if (!found_s && elig_s[sum_v[PW-1:0]]) begin
                found_s = 1'b1;
                win_s   = sum_v[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant_s = onehot_f(win_s);
        end else begin
            grant_s = {NREQ{1'b0}};
        end
    end

    // Winner operand select and signed multiply.
    always_comb begin
        a_s    = left[int'(win_s)*width +: width];
        b_s    = right[int'(win_s)*width +: width];
        a_x_s  = CW'(a_s);
        b_x_s  = CW'(b_s);
        prod_s = a_x_s * b_x_s;
    end

    // In-flight flags: clear on the edge that raises done, set on issue.
    always_comb begin
        inflight_next_s = inflight_r;
        if (fin_vld_s) begin
            inflight_next_s = inflight_next_s & ~onehot_f(fin_tag_s);
        end else begin
            inflight_next_s = inflight_next_s;
        end
        inflight_next_s = inflight_next_s | grant_s;
    end

    // Arbiter state: round-robin pointer and in-flight flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r      <= {PW{1'b0}};
            inflight_r <= {NREQ{1'b0}};
        end else begin
            inflight_r <= inflight_next_s;
            if (found_s) begin
                ptr_r <= (win_s == PW'(NREQ-1)) ? {PW{1'b0}} : win_s + PW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            localparam int D = LATENCY - 1;
            logic          vld_r  [D];
            logic [PW-1:0] tag_r  [D];
            logic [CW-1:0] prod_r [D];

            // Intermediate stages shift every cycle; there is no stall.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < D; k++) begin
                        vld_r[k]  <= 1'b0;
                        tag_r[k]  <= {PW{1'b0}};
                        prod_r[k] <= {CW{1'b0}};
                    end
                end else begin
                    vld_r[0]  <= found_s;
                    tag_r[0]  <= win_s;
                    prod_r[0] <= prod_s;
                    for (int k = 1; k < D; k++) begin
                        vld_r[k]  <= vld_r[k-1];
                        tag_r[k]  <= tag_r[k-1];
                        prod_r[k] <= prod_r[k-1];
                    end
                end
            end

            assign fin_vld_s  = vld_r[D-1];
            assign fin_tag_s  = tag_r[D-1];
            assign fin_prod_s = prod_r[D-1];
        end else begin : g_direct
            assign fin_vld_s  = found_s;
            assign fin_tag_s  = win_s;
            assign fin_prod_s = prod_s;
        end
    endgenerate

    // Final stage: registered done pulse and result; zero when nothing completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r <= {NREQ{1'b0}};
            out_r  <= {width{1'b0}};
        end else if (fin_vld_s) begin
            done_r <= onehot_f(fin_tag_s);
            out_r  <= finalize_f(fin_prod_s);
        end else begin
            done_r <= {NREQ{1'b0}};
            out_r  <= {width{1'b0}};
        end
    end

    assign done  = done_r;
    assign out   = out_r;
    assign grant = grant_s;

endmodule

// File: tb/tb_std_smult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_std_smult_arbiter
//
// Directed testbench for std_smult_arbiter. A 32-bit, 4-requester, latency-3
// instance covers arbitration, completion, fairness, reset and idle behaviour.
// An 8-bit, 2-requester instance covers wrap-around / saturation of the result
// (expected values follow STD_SMULT_ARBITER_SATURATE_EN).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle n" is the n-th clock period after stimulus is applied.
// -----------------------------------------------------------------------------
module tb_std_smult_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  go;
    logic [127:0] left;
    logic [127:0] right;
    logic [31:0] out;
    logic [3:0]  done;
    logic [3:0]  grant;

    logic [1:0]  go8;
    logic [15:0] left8;
    logic [15:0] right8;
    logic [7:0]  out8;
    logic [1:0]  done8;
    logic [1:0]  grant8;

    int n_assert;
    int n_fail;

`ifdef STD_SMULT_ARBITER_SATURATE_EN
    localparam logic [7:0] EXP_POS = 8'd127;
    localparam logic [7:0] EXP_NEG = 8'h80;
`else
    localparam logic [7:0] EXP_POS = 8'h10;
    localparam logic [7:0] EXP_NEG = 8'hF0;
`endif

    std_smult_arbiter #(.width(32), .NREQ(4), .LATENCY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .left  (left),
        .right (right),
        .out   (out),
        .done  (done),
        .grant (grant)
    );

    std_smult_arbiter #(.width(8), .NREQ(2), .LATENCY(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .go    (go8),
        .left  (left8),
        .right (right8),
        .out   (out8),
        .done  (done8),
        .grant (grant8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        nxt();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        go       = 4'b0000;
        left     = 128'd0;
        right    = 128'd0;
        go8      = 2'b00;
        left8    = 16'd0;
        right8   = 16'd0;

        // Reset state
        nxt();
        @(negedge clk);
        chk("rst_grant", grant, 32'd0);
        chk("rst_done",  done,  32'd0);
        chk("rst_out",   out,   32'd0);
        nxt();
        reset = 1'b1;

        // Single requester: (-7) * 6 on requester 1
        go = 4'b0010;
        left[32 +: 32]  = -32'sd7;
        right[32 +: 32] = 32'sd6;
        @(negedge clk); chk("t1_grant_c0", grant, 32'h2); chk("t1_done_c0", done, 32'h0);
        nxt(); @(negedge clk); chk("t1_done_c1", done, 32'h0); chk("t1_grant_c1", grant, 32'h0);
        nxt(); @(negedge clk); chk("t1_done_c2", done, 32'h0);
        nxt(); @(negedge clk); chk("t1_done_c3", done, 32'h2); chk("t1_out_c3", out, -32'sd42);
        chk("t1_grant_c3", grant, 32'h0);
        nxt(); go = 4'b0000;
        @(negedge clk); chk("t1_done_c4", done, 32'h0); chk("t1_out_c4", out, 32'h0);

        // Four requesters at once
        do_reset();
        go    = 4'b1111;
        left  = {32'sd7, -32'sd5, 32'sd3, 32'sd1};
        right = {-32'sd8, 32'sd6, 32'sd4, 32'sd2};
        @(negedge clk); chk("t2_grant_c0", grant, 32'h1);
        nxt(); @(negedge clk); chk("t2_grant_c1", grant, 32'h2);
        nxt(); @(negedge clk); chk("t2_grant_c2", grant, 32'h4);
        nxt(); @(negedge clk); chk("t2_grant_c3", grant, 32'h8);
        chk("t2_done_c3", done, 32'h1); chk("t2_out_c3", out, 32'sd2);
        nxt(); go = 4'b1110;
        @(negedge clk); chk("t2_done_c4", done, 32'h2); chk("t2_out_c4", out, 32'sd12);
        chk("t2_grant_c4", grant, 32'h0);
        nxt(); go = 4'b1100;
        @(negedge clk); chk("t2_done_c5", done, 32'h4); chk("t2_out_c5", out, -32'sd30);
        nxt(); go = 4'b1000;
        @(negedge clk); chk("t2_done_c6", done, 32'h8); chk("t2_out_c6", out, -32'sd56);
        nxt(); go = 4'b0000;

        // Fairness: requesters 0 and 2 request continuously
        do_reset();
        go = 4'b0101;
        left  = 128'd0;
        right = 128'd0;
        left[0 +: 32]  = 32'sd3;
        right[0 +: 32] = -32'sd3;
        left[64 +: 32]  = -32'sd4;
        right[64 +: 32] = -32'sd5;
        @(negedge clk); chk("t3_grant_c0", grant, 32'h1);
        nxt(); @(negedge clk); chk("t3_grant_c1", grant, 32'h4);
        nxt(); @(negedge clk); chk("t3_grant_c2", grant, 32'h0);
        nxt(); @(negedge clk); chk("t3_done_c3", done, 32'h1); chk("t3_out_c3", out, -32'sd9);
        chk("t3_grant_c3", grant, 32'h0);
        nxt(); @(negedge clk); chk("t3_done_c4", done, 32'h4); chk("t3_out_c4", out, 32'sd20);
        chk("t3_grant_c4", grant, 32'h1);
        nxt(); @(negedge clk); chk("t3_grant_c5", grant, 32'h4);
        nxt(); @(negedge clk); chk("t3_grant_c6", grant, 32'h0);
        nxt(); @(negedge clk); chk("t3_done_c7", done, 32'h1); chk("t3_out_c7", out, -32'sd9);
        nxt(); go = 4'b0000;

        // Reset while requester 3 is in flight
        do_reset();
        go = 4'b1000;
        left[96 +: 32]  = 32'sd5;
        right[96 +: 32] = 32'sd5;
        @(negedge clk); chk("t4_grant_c0", grant, 32'h8);
        nxt(); reset = 1'b0; go = 4'b0000;
        @(negedge clk); chk("t4_done_c1", done, 32'h0); chk("t4_out_c1", out, 32'h0);
        nxt(); reset = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4_done_c%0d", c), done, 32'h0);
            chk($sformatf("t4_out_c%0d", c), out, 32'h0);
            nxt();
        end
        go = 4'b1001;
        @(negedge clk); chk("t4_grant_c6", grant, 32'h1);
        nxt(); go = 4'b0000;

        // Idle
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle_grant_c%0d", c), grant, 32'h0);
            chk($sformatf("idle_done_c%0d", c), done, 32'h0);
            chk($sformatf("idle_out_c%0d", c), out, 32'h0);
            nxt();
        end

        // 8-bit result range: 100*100 then (-100)*100
        go8 = 2'b01;
        left8[7:0]  = 8'd100;
        right8[7:0] = 8'd100;
        @(negedge clk); chk("t5_grant_c0", grant8, 32'h1);
        nxt(); nxt();
        nxt(); @(negedge clk); chk("t5_done_c3", done8, 32'h1); chk("t5_out_pos", out8, EXP_POS);
        nxt(); go8 = 2'b10;
        left8[15:8]  = 8'h9C;
        right8[15:8] = 8'd100;
        @(negedge clk); chk("t5_grant_c4", grant8, 32'h2); chk("t5_done_c4", done8, 32'h0);
        nxt(); nxt();
        nxt(); @(negedge clk); chk("t5_done_c7", done8, 32'h2); chk("t5_out_neg", out8, EXP_NEG);
        nxt(); go8 = 2'b00;
        @(negedge clk); chk("t5_out_c8", out8, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
